// File: rtl/ats_eligibility_time_calc.sv
// ATS single-shaper eligibility time calculator: deserializes per-frame length and
// arrival timestamp byte streams, then runs one token-bucket update per frame.
module ats_eligibility_time_calc #(
  parameter int DATA_WIDTH         = 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int RATE_WIDTH         = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RATE_WIDTH-1:0]         ps_per_byte,
  input  logic [TIMESTAMP_WIDTH-1:0]    empty_to_full_ps,
  input  logic [TIMESTAMP_WIDTH-1:0]    max_residence_ps,
  input  logic [DATA_WIDTH-1:0]         s_axis_frame_length_tdata,
  input  logic                          s_axis_frame_length_tvalid,
  output logic                          s_axis_frame_length_tready,
  input  logic                          s_axis_frame_length_tlast,
  input  logic [DATA_WIDTH-1:0]         s_axis_timestamp_tdata,
  input  logic                          s_axis_timestamp_tvalid,
  output logic                          s_axis_timestamp_tready,
  input  logic                          s_axis_timestamp_tlast,
  output logic [TIMESTAMP_WIDTH-1:0]    m_axis_eligibility_tdata,
  output logic                          m_axis_eligibility_tuser,
  output logic                          m_axis_eligibility_tvalid,
  input  logic                          m_axis_eligibility_tready
);

  localparam int TW = TIMESTAMP_WIDTH;
  localparam int FW = FRAME_LENGTH_WIDTH;

  typedef enum logic [1:0] {COLLECT, CALC1, CALC2, OUTPUT} state_t;

  state_t          state_reg, state_next;
  logic [FW-1:0]   len_reg;
  logic [TW-1:0]   ts_reg;
  logic            len_done_reg, ts_done_reg;
  logic [TW-1:0]   bucket_empty_reg, group_elig_reg;
  logic            first_frame_reg;
  logic [TW-1:0]   sched_reg, full_reg, limit_reg;
  logic [TW-1:0]   elig_reg;
  logic            drop_reg, valid_reg;

  logic            len_accept, ts_accept;
  logic [FW+DATA_WIDTH-1:0] len_cat;
  logic [TW+DATA_WIDTH-1:0] ts_cat;
  logic [FW+RATE_WIDTH-1:0] len_prod;
  logic [TW-1:0]   base, len_dur, elig_a, elig, bucket_next;
  logic            drop;

  assign s_axis_frame_length_tready = (state_reg == COLLECT) && !len_done_reg;
  assign s_axis_timestamp_tready    = (state_reg == COLLECT) && !ts_done_reg;
  assign len_accept = s_axis_frame_length_tvalid && s_axis_frame_length_tready;
  assign ts_accept  = s_axis_timestamp_tvalid && s_axis_timestamp_tready;

  // Shift left by one byte; the concatenation drops the oldest byte once full.
  assign len_cat = {len_reg, s_axis_frame_length_tdata};
  assign ts_cat  = {ts_reg, s_axis_timestamp_tdata};

  assign m_axis_eligibility_tdata  = elig_reg;
  assign m_axis_eligibility_tuser  = drop_reg;
  assign m_axis_eligibility_tvalid = valid_reg;

  always_comb begin
    base = bucket_empty_reg;
    if (first_frame_reg)
      base = (ts_reg < empty_to_full_ps) ? '0 : ts_reg - empty_to_full_ps;
    len_prod = len_reg * ps_per_byte;
    len_dur  = TW'(len_prod);
  end

  always_comb begin
    elig_a = (ts_reg > group_elig_reg) ? ts_reg : group_elig_reg;
    elig   = (elig_a > sched_reg) ? elig_a : sched_reg;
    drop   = elig > limit_reg;
    // Bucket overflowed past full: credit beyond the burst is discarded.
    bucket_next = (elig < full_reg) ? sched_reg : sched_reg + elig - full_reg;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (len_done_reg && ts_done_reg) state_next = CALC1;
      CALC1:   state_next = CALC2;
      CALC2:   state_next = OUTPUT;
      OUTPUT:  if (m_axis_eligibility_tready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= COLLECT;
      len_reg          <= '0;
      ts_reg           <= '0;
      len_done_reg     <= 1'b0;
      ts_done_reg      <= 1'b0;
      bucket_empty_reg <= '0;
      group_elig_reg   <= '0;
      first_frame_reg  <= 1'b1;
      sched_reg        <= '0;
      full_reg         <= '0;
      limit_reg        <= '0;
      elig_reg         <= '0;
      drop_reg         <= 1'b0;
      valid_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        COLLECT: begin
          if (len_accept) begin
            len_reg <= len_cat[FW-1:0];
            if (s_axis_frame_length_tlast) len_done_reg <= 1'b1;
          end
          if (ts_accept) begin
            ts_reg <= ts_cat[TW-1:0];
            if (s_axis_timestamp_tlast) ts_done_reg <= 1'b1;
          end
        end
        CALC1: begin
          sched_reg <= base + len_dur;
          full_reg  <= base + empty_to_full_ps;
          limit_reg <= ts_reg + max_residence_ps;
        end
        CALC2: begin
          elig_reg  <= elig;
          drop_reg  <= drop;
          valid_reg <= 1'b1;
          if (!drop) begin
            group_elig_reg   <= elig;
            bucket_empty_reg <= bucket_next;
            first_frame_reg  <= 1'b0;
          end
        end
        OUTPUT: begin
          if (m_axis_eligibility_tready) begin
            valid_reg    <= 1'b0;
            len_done_reg <= 1'b0;
            ts_done_reg  <= 1'b0;
            len_reg      <= '0;
            ts_reg       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ats_eligibility_time_calc.sv
// Scoreboard bench for ats_eligibility_time_calc: a reference token-bucket model
// queues expected results per frame; a monitor pops them on each output handshake.
module tb_ats_eligibility_time_calc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ps_per_byte;
  logic [71:0] empty_to_full_ps, max_residence_ps;
  logic [7:0]  len_tdata = '0, ts_tdata = '0;
  logic        len_tvalid = 1'b0, len_tlast = 1'b0, len_tready;
  logic        ts_tvalid = 1'b0, ts_tlast = 1'b0, ts_tready;
  logic [71:0] m_tdata;
  logic        m_tuser, m_tvalid;
  logic        m_tready = 1'b1;

  always #5 clk = ~clk;

  ats_eligibility_time_calc dut (
    .clk(clk), .rst(rst),
    .ps_per_byte(ps_per_byte), .empty_to_full_ps(empty_to_full_ps),
    .max_residence_ps(max_residence_ps),
    .s_axis_frame_length_tdata(len_tdata), .s_axis_frame_length_tvalid(len_tvalid),
    .s_axis_frame_length_tready(len_tready), .s_axis_frame_length_tlast(len_tlast),
    .s_axis_timestamp_tdata(ts_tdata), .s_axis_timestamp_tvalid(ts_tvalid),
    .s_axis_timestamp_tready(ts_tready), .s_axis_timestamp_tlast(ts_tlast),
    .m_axis_eligibility_tdata(m_tdata), .m_axis_eligibility_tuser(m_tuser),
    .m_axis_eligibility_tvalid(m_tvalid), .m_axis_eligibility_tready(m_tready)
  );

  typedef struct {
    logic [71:0] elig;
    logic        drop;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0, n_out = 0;

  logic [71:0] mdl_bucket, mdl_group;
  logic        mdl_first;

  task automatic check_value(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mdl_bucket = '0;
    mdl_group  = '0;
    mdl_first  = 1'b1;
    sb.delete();
  endtask

  task automatic model_frame(input logic [15:0] len, input logic [71:0] arr);
    logic [71:0] base, sched, full, limit, elig;
    exp_t e;
    if (mdl_first) base = (arr < empty_to_full_ps) ? 72'd0 : arr - empty_to_full_ps;
    else           base = mdl_bucket;
    sched = base + 72'(len) * 72'(ps_per_byte);
    full  = base + empty_to_full_ps;
    limit = arr + max_residence_ps;
    elig  = arr;
    if (mdl_group > elig) elig = mdl_group;
    if (sched > elig)     elig = sched;
    e.elig = elig;
    e.drop = (elig > limit);
    if (!e.drop) begin
      mdl_group  = elig;
      mdl_bucket = (elig < full) ? sched : sched + elig - full;
      mdl_first  = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Handshake completes at the next posedge when valid and ready are both high here.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      exp_t e;
      if (sb.size() == 0) begin
        check_value("unexpected_output", 72'd1, 72'd0);
      end else begin
        e = sb.pop_front();
        check_value("elig", m_tdata, e.elig);
        check_value("drop", 72'(m_tuser), 72'(e.drop));
        $display("frame %0d: elig=%0d drop=%0b", n_out, m_tdata, m_tuser);
      end
      n_out++;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    len_tvalid = 1'b0; ts_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // Streams both fields; len_start/ts_start delay each stream's first beat by cycles.
  task automatic send_frame(input logic [15:0] len, input logic [71:0] arr,
                            input int len_start, input int ts_start, input bit chk_lat);
    int li = 0, ti = 0, c = 0, lat;
    model_frame(len, arr);
    while ((li < 2 || ti < 9) && c < 400) begin
      @(posedge clk); #1;
      len_tvalid = (c >= len_start) && (li < 2);
      len_tdata  = len[15 - 8*li -: 8];
      len_tlast  = (li == 1);
      ts_tvalid  = (c >= ts_start) && (ti < 9);
      ts_tdata   = arr[71 - 8*ti -: 8];
      ts_tlast   = (ti == 8);
      @(negedge clk);
      if (ti == 9 && li < 2) check_value("ts_tready_after_done", 72'(ts_tready), 72'd0);
      if (li == 2 && ti < 9) check_value("len_tready_after_done", 72'(len_tready), 72'd0);
      if (len_tvalid && len_tready) li++;
      if (ts_tvalid && ts_tready) ti++;
      c++;
    end
    if (c >= 400) check_value("input_timeout", 72'd1, 72'd0);
    @(posedge clk); #1;
    len_tvalid = 1'b0; ts_tvalid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!m_tvalid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (chk_lat) check_value("latency", 72'(lat), 72'd3);
    else if (!m_tvalid) check_value("output_timeout", 72'd1, 72'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 200) begin
      @(negedge clk); n++;
    end
    check_value("drain", 72'(sb.size()), 72'd0);
  endtask

  initial begin
    logic [71:0] held;
    logic        held_u;
    logic [71:0] arr;
    ps_per_byte      = 32'd8000;
    empty_to_full_ps = 72'd12_000_000;
    max_residence_ps = 72'd1_000_000_000;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_value("rst_tvalid", 72'(m_tvalid), 72'd0);
    check_value("rst_tdata", m_tdata, 72'd0);
    check_value("rst_tuser", 72'(m_tuser), 72'd0);
    check_value("rst_len_tready", 72'(len_tready), 72'd1);
    check_value("rst_ts_tready", 72'(ts_tready), 72'd1);

    // First frame, then a burst
    send_frame(16'd64,   72'd1_000_000, 0, 0, 1);
    send_frame(16'd1500, 72'd1_000_008, 0, 0, 1);
    send_frame(16'd64,   72'd1_000_016, 0, 0, 1);
    drain();

    // Ordering: timestamp done 5 cycles before length, then same-cycle tlasts
    do_reset();
    send_frame(16'd64,   72'd1_000_000, 12, 0, 1);
    send_frame(16'd1500, 72'd1_000_008, 7, 0, 1);
    drain();

    // Backpressure on the output
    m_tready = 1'b0;
    send_frame(16'd64, 72'd1_000_016, 0, 0, 1);
    held = m_tdata; held_u = m_tuser;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_value("bp_tdata", m_tdata, held);
      check_value("bp_tuser", 72'(m_tuser), 72'(held_u));
      check_value("bp_tvalid", 72'(m_tvalid), 72'd1);
      check_value("bp_len_tready", 72'(len_tready), 72'd0);
      check_value("bp_ts_tready", 72'(ts_tready), 72'd0);
    end
    @(posedge clk); #1 m_tready = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    check_value("bp_single_output", 72'(m_tvalid), 72'd0);

    // Drop: state must be unchanged, so a repeated frame gives the same result
    max_residence_ps = 72'd0;
    do_reset();
    send_frame(16'd64,   72'd1_000_000, 0, 0, 1);
    send_frame(16'd1500, 72'd1_000_008, 0, 0, 1);
    send_frame(16'd1500, 72'd1_000_008, 0, 0, 1);
    drain();

    // Reset after one length byte: no output, next frame takes the first-frame path
    max_residence_ps = 72'd1_000_000_000;
    @(posedge clk); #1;
    len_tvalid = 1'b1; len_tdata = 8'h00; len_tlast = 1'b0;
    @(posedge clk); #1 len_tvalid = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_value("abort_no_output", 72'(m_tvalid), 72'd0);
    end
    send_frame(16'd64, 72'd1_000_000, 0, 0, 1);
    drain();

    // Assorted frames with varying spacing
    arr = 72'd2_000_000;
    for (int i = 0; i < 6; i++) begin
      arr = arr + 72'($urandom_range(0, 20_000_000));
      send_frame(16'($urandom_range(64, 1500)), arr,
                 $urandom_range(0, 6), $urandom_range(0, 6), 1);
    end
    drain();
    check_value("sb_empty_end", 72'(sb.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ats_eligibility_time_calc.md
Name: ats_eligibility_time_calc

Overview:
- Downstream consumer of get_frame_length_and_timestamp in the ATS path.
- Deserializes the per-frame byte-serial frame-length and arrival-timestamp streams into parallel words.
- Runs one ATS token-bucket eligibility calculation per frame (IEEE 802.1Qcr semantics, single shaper).
- Emits the frame's eligibility time plus a drop flag to the ATS scheduler queue. The frame data stream itself does not pass through this block.

Parameters:
- DATA_WIDTH, 8, byte width of both input streams.
- FRAME_LENGTH_WIDTH, 16, frame-length word width; multiple of DATA_WIDTH.
- TIMESTAMP_WIDTH, 72, timestamp/time width in ps; multiple of DATA_WIDTH.
- RATE_WIDTH, 32, width of ps_per_byte.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- ps_per_byte  in  RATE_WIDTH  committed rate as ps per byte.
- empty_to_full_ps  in  TIMESTAMP_WIDTH  committed burst expressed as ps (CBS*ps_per_byte).
- max_residence_ps  in  TIMESTAMP_WIDTH  max residence time.
- s_axis_frame_length_tdata  in  DATA_WIDTH  length byte, MSB first.
- s_axis_frame_length_tvalid  in  1
- s_axis_frame_length_tready  out  1
- s_axis_frame_length_tlast  in  1  last length byte.
- s_axis_timestamp_tdata  in  DATA_WIDTH  timestamp byte, MSB first.
- s_axis_timestamp_tvalid  in  1
- s_axis_timestamp_tready  out  1
- s_axis_timestamp_tlast  in  1  last timestamp byte.
- m_axis_eligibility_tdata  out  TIMESTAMP_WIDTH  eligibility time (ps).
- m_axis_eligibility_tuser  out  1  1 = frame must be dropped.
- m_axis_eligibility_tvalid  out  1
- m_axis_eligibility_tready  in  1

Behaviour:
- Reset (rst=1 at posedge):
  - State -> COLLECT.
  - All outputs 0, except both s_*_tready, which are 1 in COLLECT after reset.
  - bucket_empty_time = 0, group_elig_time = 0, first_frame = 1.
  - Partial deserialized words are discarded.
- Deserialization:
  - Each stream has its own shift register: on each accepted beat, reg <= {reg, tdata}, truncated to word width.
  - Each stream's tlast sets a per-stream done flag; that stream's tready drops the cycle after its tlast is accepted.
  - Extra beats keep only the last word-width bytes. Short streams are zero-extended (register cleared on entering COLLECT).
  - The two streams complete independently, in either order or on the same cycle.
- FSM COLLECT -> CALC1 -> CALC2 -> OUTPUT -> COLLECT.
- COLLECT -> CALC1 the cycle after both done flags are set. If the later tlast is accepted at cycle T: CALC1 at T+1, CALC2 at T+2, m_axis_eligibility_tvalid=1 from T+3.
- CALC1 (config sampled here), registered:
  - base = first_frame ? sat0(arrival - empty_to_full_ps) : bucket_empty_time
  - len_dur = frame_length * ps_per_byte (full product, zero-extended/truncated to TIMESTAMP_WIDTH)
  - sched = base + len_dur
  - full = base + empty_to_full_ps
  - limit = arrival + max_residence_ps
- CALC2:
  - elig = max(arrival, group_elig_time, sched), unsigned.
  - drop = (elig > limit).
  - If !drop:
    - group_elig_time <= elig.
    - bucket_empty_time <= (elig < full) ? sched : sched + elig - full.
    - first_frame <= 0.
  - If drop: all state is unchanged, first_frame included.
- OUTPUT:
  - tdata=elig, tuser=drop, tvalid=1; held stable until tvalid&tready.
  - On handshake: tvalid <= 0, next state COLLECT, done flags cleared, both s_*_tready <= 1.
- Input tready is 0 in CALC1, CALC2 and OUTPUT.
- Arithmetic is modulo 2^TIMESTAMP_WIDTH. Comparisons are unsigned; there is no wrap handling.
- sat0: if arrival < empty_to_full_ps, the result is 0.
- Reset mid-frame or mid-calc aborts the calculation; no output for that frame.
- Config changes outside CALC1 have no effect on the frame in flight.

Test Plan:
(All scenarios use ps_per_byte=8000, empty_to_full_ps=12_000_000, max_residence_ps=1_000_000_000 unless stated.)
- First frame: len 64, arrival 1_000_000 -> elig 1_000_000, tuser 0. Internally: bucket_empty_time=512_000, group=1_000_000.
- Burst: after the first frame, len 1500, arrival 1_000_008 -> elig 12_512_000, tuser 0. Then len 64, arrival 1_000_016 -> elig 13_024_000.
- Drop: max_residence_ps=0, second frame len 1500, arrival 1_000_008 -> tuser 1, elig 12_512_000. A repeated identical frame gives the identical result (state unchanged).
- Ordering/latency:
  - Timestamp completes 5 cycles before length -> tvalid rises exactly 3 cycles after the length tlast handshake.
  - Both tlasts on the same cycle -> also 3 cycles.
- Backpressure: m_axis_eligibility_tready low 20 cycles -> tdata/tuser stable and both s_*_tready=0 throughout; one output per frame.
- Reset: rst asserted after one length byte -> no output. The next frame (len 64, arrival 1_000_000) yields elig 1_000_000 via the first_frame path.
